pe_column_normalizer: RTL and testbench
=======================================

# pe_column_normalizer

Consumes the stream of 48-bit column partial sums produced by the DSP multiply-accumulate processing elements and resolves it into canonical K-bit radix digits. A column sum arrives LSW first. The block adds the running carry, emits the low K bits as a digit, and keeps the high bits as the next carry. After the last column it flushes the residual carry as extra digits. It sits between the PE array output and the Montgomery reduction and writeback logic of the BN254 datapath.

## Interface
- K, 17, digit width in bits; must be 10..24
- NW, 15, column sums per frame
- CW, 49-K, carry register width (derived; not overridable)
- F, ceil(CW/K), number of flush digits (2 at K=17)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  column sum valid
- in_ready  out  1  block accepts column sum this cycle
- in_s  in  48  column partial sum, unsigned
- in_last  in  1  marks final column of frame
- out_valid  out  1  digit valid
- out_ready  in  1  downstream accepts digit
- out_digit  out  K  normalized digit
- out_idx  out  $clog2(NW+F)  digit index within frame, 0-based
- out_last  out  1  final digit of frame (last flush digit)
- frame_err  out  1  sticky; in_last index mismatch or overrun

## Operation
- The FSM has two states, RUN and FLUSH. Reset enters RUN with carry=0, idx=0, and all outputs 0.
- RUN: on an input handshake (in_valid & in_ready), compute acc = in_s + carry, 49 bits. Then out_digit <= acc[K-1:0], carry <= acc[48:K], and out_idx <= idx, then idx++.
- If in_last is accepted, go to FLUSH with fcnt=0.
- FLUSH: each time the output register is free, emit out_digit = carry[K-1:0] and shift carry right by K. The emitted index is NW+fcnt; increment fcnt after each emission.
- On fcnt=F-1, assert out_last with that digit, then clear carry and idx and return to RUN. The residual carry is provably 0 at that point.
- in_ready = (state==RUN) & (!out_valid | out_ready). No input is accepted in FLUSH.
- The output register holds its value, and out_valid stays high until out_valid & out_ready.
- frame_err is set, and stays set until rst_n, in either case:
  - in_last accepted with idx != NW-1;
  - a column accepted at idx == NW-1 without in_last.
  
  In the overrun case the block behaves as if in_last were set: it flushes, and the extra column is still normalized.
- The arithmetic is unsigned. The 48-bit input plus a CW-bit carry cannot overflow 49 bits for any K >= 10.

## Timing
- Latency: a column accepted in cycle t produces its digit with out_valid=1 in cycle t+1.
- Throughput is 1 digit/cycle with out_ready held high. A frame of NW columns occupies NW+F output cycles.
- The first flush digit appears the cycle after the digit of the last column, provided it is consumed. Flush digits are back-to-back.
- The first column of the next frame may be accepted in the same cycle the out_last digit handshakes.
- Backpressure: while out_ready=0, out_digit, out_idx and out_last are held stable and in_ready=0.
- rst_n low at any time, including mid-frame or mid-flush, immediately clears state, carry, idx, fcnt, out_valid, out_last and frame_err. out_digit and out_idx reset to 0.

## Test plan
- **Basic carry (NW=2, K=17).** Send 0x30001, then 0x1FFFF with in_last.
  - Required digits and indices: 0x10001 (idx0), 0x00000 (idx1), 0x00001 (idx2), 0x00000 (idx3, out_last=1).
  - frame_err=0.
- **Max sums (NW=15).** Send all in_s = 2^48-1.
  - The recombined value sum(digit_i·2^(17i)) must equal sum(s_i·2^(17i)) from the model.
  - 17 digits are emitted, with out_last only on idx16.
- **Backpressure.** Hold out_ready=0 for 3 cycles mid-frame and mid-flush.
  - Outputs stay stable and in_ready=0 throughout.
  - No digit is lost or duplicated.
  - Throughput returns to 1/cycle afterwards.
- **Back-to-back frames.** Start the second frame on the out_last handshake cycle.
  - The second frame's digit idx0 uses carry=0 and appears one cycle later.
- **Frame error (NW=2).**
  - in_last on the first column: frame_err=1, then 2 flush digits follow.
  - Separately, 2 columns without in_last: frame_err=1 and a flush occurs after the second column.
- **Reset mid-flush.** Assert rst_n=0 during the first flush digit.
  - out_valid=0 and frame_err=0 immediately.
  - The next frame's digits are computed with carry=0.

Source files
------------

// File: rtl/pe_column_normalizer.sv
// pe_column_normalizer: resolves 48-bit PE column sums into K-bit radix digits and flushes the residual carry
module pe_column_normalizer #(
    parameter int K = 17,
    parameter int NW = 15,
    localparam int CW = 49 - K,
    localparam int F = (CW + K - 1) / K,
    localparam int IW = $clog2(NW + F)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [47:0]   in_s,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [K-1:0]  out_digit,
    output logic [IW-1:0] out_idx,
    output logic          out_last,
    output logic          frame_err
);
    localparam int FW = $clog2(F);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] carry;
    logic [IW-1:0] idx;
    logic [FW-1:0] fcnt;
    logic [48:0]   acc;
    logic          free, take, emit, at_end, fdone;

    assign free   = !out_valid || out_ready;
    assign take   = in_valid && in_ready;
    assign emit   = (state == FLUSH) && free;
    assign acc    = 49'(in_s) + 49'(carry);
    assign at_end = idx == IW'(NW - 1);
    assign fdone  = fcnt == FW'(F - 1);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else state <= state_nx;
    end

    // leave RUN on the frame's final (or overrunning) column, return after the last flush digit
    always_comb begin
        state_nx = (take && (in_last || at_end)) ? FLUSH : (emit && fdone) ? RUN : state;
    end

    // columns are only taken in RUN and only when the output register can be refilled
    always_comb begin
        in_ready = (state == RUN) && free;
    end

    // digit register, running carry, column/flush counters and sticky framing error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry     <= '0;
            idx       <= '0;
            fcnt      <= '0;
            out_valid <= 1'b0;
            out_digit <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (take) begin
                out_digit <= acc[K-1:0];
                carry     <= acc[48:K];
                out_idx   <= idx;
                out_last  <= 1'b0;
                idx       <= idx + IW'(1);
                fcnt      <= '0;
                if (in_last != at_end) frame_err <= 1'b1;
            end else if (emit) begin
                out_digit <= carry[K-1:0];
                carry     <= fdone ? '0 : carry >> K;
                out_idx   <= IW'(NW) + IW'(fcnt);
                out_last  <= fdone;
                fcnt      <= fcnt + FW'(1);
                if (fdone) idx <= '0;
            end
            out_valid <= take || emit || (out_valid && !out_ready);
        end
    end
endmodule

// File: tb/tb_pe_column_normalizer.sv
// tb_pe_column_normalizer: frame-level scoreboard plus directed vectors for two normalizer instances (NW=2, NW=15)
module tb_pe_column_normalizer;
    localparam int K = 17;
    localparam int F = 2;

    typedef struct packed {
        logic [K-1:0] dg;
        logic [7:0]   ix;
        logic         lst;
    } ex_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         iv [2], ir [2], il [2], ov [2], ordy [2], ol [2], fe [2];
    logic [47:0]  ins [2];
    logic [K-1:0] od [2];
    logic [1:0]   oi_a;
    logic [4:0]   oi_b;
    int           oi [2];

    ex_t          eq [2][64];
    ex_t          e_tmp;
    int           hd [2], tl [2];
    logic [511:0] mv [2];
    int           mn [2];
    logic         merr [2], pst [2], pend [2], pl [2];
    logic [K-1:0] pd [2];
    int           pi [2];

    logic [K-1:0] cd [2][256];
    int           ci [2][256];
    logic         cl [2][256];
    int           cc [2][256];
    int           cn [2] = '{0, 0};
    int           cyc = 0;
    int           n_chk = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    // cycle stamp for throughput measurements
    always @(posedge clk) cyc <= cyc + 1;

    // widen the two index ports to a common type
    always_comb begin
        oi[0] = 32'(oi_a);
        oi[1] = 32'(oi_b);
    end

    pe_column_normalizer #(.K(K), .NW(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_s(ins[0]), .in_last(il[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_digit(od[0]), .out_idx(oi_a), .out_last(ol[0]),
        .frame_err(fe[0])
    );

    pe_column_normalizer #(.K(K), .NW(15)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_s(ins[1]), .in_last(il[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_digit(od[1]), .out_idx(oi_b), .out_last(ol[1]),
        .frame_err(fe[1])
    );

    function automatic int nw(input int d);
        return d == 0 ? 2 : 15;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int d, input logic [K-1:0] dg, input int ix, input bit l);
        eq[d][tl[d] % 64] = '{dg, 8'(ix), l};
        tl[d]++;
    endtask

    // scoreboard: the frame value is accumulated as a wide integer and its K-bit chunks are the expected digits
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                chk("reset_out_valid", 512'(ov[d]), 0);
                chk("reset_frame_err", 512'(fe[d]), 0);
                hd[d] = 0; tl[d] = 0; mv[d] = '0; mn[d] = 0;
                merr[d] = 0; pst[d] = 0; pend[d] = 0;
            end else begin
                chk("frame_err", 512'(fe[d]), 512'(merr[d]));
                if (pend[d]) chk("latency_out_valid", 512'(ov[d]), 1);
                if (pst[d]) begin
                    chk("hold_digit", 512'(od[d]), 512'(pd[d]));
                    chk("hold_idx", 512'(oi[d]), 512'(pi[d]));
                    chk("hold_last", 512'(ol[d]), 512'(pl[d]));
                    chk("hold_valid", 512'(ov[d]), 1);
                end
                if (ov[d] && !ordy[d]) chk("stall_in_ready", 512'(ir[d]), 0);
                if (ov[d] && ordy[d]) begin
                    if (hd[d] == tl[d]) begin
                        chk("unexpected_digit_idx", 512'(oi[d]), 512'hFFFF);
                    end else begin
                        e_tmp = eq[d][hd[d] % 64];
                        hd[d]++;
                        chk("digit", 512'(od[d]), 512'(e_tmp.dg));
                        chk("digit_idx", 512'(oi[d]), 512'(e_tmp.ix));
                        chk("digit_last", 512'(ol[d]), 512'(e_tmp.lst));
                    end
                    if (cn[d] < 256) begin
                        cd[d][cn[d]] = od[d]; ci[d][cn[d]] = oi[d];
                        cl[d][cn[d]] = ol[d]; cc[d][cn[d]] = cyc;
                        cn[d]++;
                    end
                end
                pst[d] = ov[d] && !ordy[d];
                pd[d] = od[d]; pi[d] = oi[d]; pl[d] = ol[d];
                pend[d] = iv[d] && ir[d];
                if (iv[d] && ir[d]) begin
                    mv[d] = mv[d] + (512'(ins[d]) << (K * mn[d]));
                    push(d, mv[d][K*mn[d] +: K], mn[d], 1'b0);
                    mn[d]++;
                    if (il[d] || mn[d] == nw(d)) begin
                        if (il[d] != (mn[d] == nw(d))) merr[d] = 1'b1;
                        for (int j = 0; j < F; j++) push(d, mv[d][K*(mn[d]+j) +: K], nw(d) + j, j == F - 1);
                        mv[d] = '0;
                        mn[d] = 0;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic [47:0] s, input bit l);
        int w = 0;
        iv[d] = 1'b1; ins[d] = s; il[d] = l;
        @(negedge clk);
        while (!ir[d] && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("send_accepted", 512'(ir[d]), 1);
        @(posedge clk);
        #1;
        iv[d] = 1'b0; il[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int w = 0;
        while ((hd[d] != tl[d] || ov[d]) && w < 200) begin
            tick(1);
            w++;
        end
        chk("drain_done", 512'(hd[d] == tl[d] && !ov[d]), 1);
    endtask

    // global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // directed stimulus with literal expectations
    initial begin
        int m, nl;
        int bd [4];
        logic [511:0] mx, rc;
        iv = '{1'b0, 1'b0}; il = '{1'b0, 1'b0}; ins = '{48'd0, 48'd0}; ordy = '{1'b1, 1'b1};
        rst_n = 1'b0;
        tick(3);
        for (int d = 0; d < 2; d++) begin
            chk("reset_digit", 512'(od[d]), 0);
            chk("reset_idx", 512'(oi[d]), 0);
            chk("reset_last", 512'(ol[d]), 0);
        end
        rst_n = 1'b1;
        tick(1);

        m = cn[0];
        bd = '{'h10001, 0, 1, 0};
        send(0, 48'h30001, 1'b0);
        send(0, 48'h1FFFF, 1'b1);
        drain(0);
        chk("basic_count", 512'(cn[0] - m), 4);
        for (int i = 0; i < 4; i++) begin
            chk("basic_digit", 512'(cd[0][m+i]), 512'(bd[i]));
            chk("basic_idx", 512'(ci[0][m+i]), 512'(i));
            chk("basic_last", 512'(cl[0][m+i]), 512'(i == 3));
        end
        chk("basic_frame_err", 512'(fe[0]), 0);

        m = cn[1]; mx = '0; rc = '0; nl = 0;
        for (int i = 0; i < 15; i++) begin
            send(1, '1, i == 14);
            mx = mx + (512'(48'hFFFF_FFFF_FFFF) << (K * i));
        end
        drain(1);
        chk("max_count", 512'(cn[1] - m), 17);
        for (int i = 0; i < 17; i++) begin
            rc = rc + (512'(cd[1][m+i]) << (K * ci[1][m+i]));
            nl += int'(cl[1][m+i]);
            chk("max_idx", 512'(ci[1][m+i]), 512'(i));
        end
        chk("max_value", rc, mx);
        chk("max_last_count", 512'(nl), 1);
        chk("max_last_pos", 512'(cl[1][m+16]), 1);
        chk("max_throughput", 512'(cc[1][m+16] - cc[1][m]), 16);

        m = cn[1];
        for (int i = 0; i < 5; i++) send(1, 48'(i) * 48'h1_2345_6789 + 48'hABCDE, 1'b0);
        ordy[1] = 1'b0;
        tick(3);
        ordy[1] = 1'b1;
        for (int i = 5; i < 15; i++) send(1, 48'(i) * 48'h1_2345_6789 + 48'hABCDE, i == 14);
        tick(1);
        ordy[1] = 1'b0;
        tick(3);
        ordy[1] = 1'b1;
        drain(1);
        chk("bp_count", 512'(cn[1] - m), 17);
        chk("bp_run_gap", 512'(cc[1][m+4] - cc[1][m+3]), 4);
        chk("bp_run_resume", 512'(cc[1][m+5] - cc[1][m+4]), 1);
        chk("bp_flush_gap", 512'(cc[1][m+15] - cc[1][m+14]), 4);
        chk("bp_flush_resume", 512'(cc[1][m+16] - cc[1][m+15]), 1);

        m = cn[0];
        send(0, 48'h3FFFF, 1'b0);
        send(0, 48'h3FFFF, 1'b1);
        send(0, 48'h20005, 1'b0);
        send(0, 48'h10, 1'b1);
        drain(0);
        chk("b2b_count", 512'(cn[0] - m), 8);
        chk("b2b_a_flush0", 512'(cd[0][m+2]), 2);
        chk("b2b_a_last", 512'(cl[0][m+3]), 1);
        chk("b2b_start_gap", 512'(cc[0][m+4] - cc[0][m+3]), 1);
        chk("b2b_digit0", 512'(cd[0][m+4]), 5);
        chk("b2b_idx0", 512'(ci[0][m+4]), 0);
        chk("b2b_digit1", 512'(cd[0][m+5]), 'h11);

        m = cn[0];
        send(0, 48'h55, 1'b1);
        drain(0);
        chk("err_early_flag", 512'(fe[0]), 1);
        chk("err_early_count", 512'(cn[0] - m), 3);
        chk("err_early_idx1", 512'(ci[0][m+1]), 2);
        chk("err_early_idx2", 512'(ci[0][m+2]), 3);
        chk("err_early_last", 512'(cl[0][m+2]), 1);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        m = cn[0];
        send(0, 48'h1, 1'b0);
        send(0, 48'h2, 1'b0);
        drain(0);
        chk("err_overrun_flag", 512'(fe[0]), 1);
        chk("err_overrun_count", 512'(cn[0] - m), 4);
        chk("err_overrun_idx2", 512'(ci[0][m+2]), 2);
        chk("err_overrun_last", 512'(cl[0][m+3]), 1);

        send(0, 48'h30001, 1'b0);
        send(0, 48'hFFFF_FFFF_FFFF, 1'b1);
        @(posedge clk);
        #2;
        chk("pre_rst_idx", 512'(oi[0]), 2);
        chk("pre_rst_err", 512'(fe[0]), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 512'(ov[0]), 0);
        chk("rst_frame_err", 512'(fe[0]), 0);
        chk("rst_idx", 512'(oi[0]), 0);
        chk("rst_digit", 512'(od[0]), 0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        m = cn[0];
        send(0, 48'h20003, 1'b0);
        send(0, 48'h7, 1'b1);
        drain(0);
        chk("post_rst_digit0", 512'(cd[0][m]), 3);
        chk("post_rst_idx0", 512'(ci[0][m]), 0);
        chk("post_rst_digit1", 512'(cd[0][m+1]), 8);
        chk("post_rst_frame_err", 512'(fe[0]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
